// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 write sequencer: command bytes, the
// sequencer and byte-writer state encodings, and the custom glyph table
// loaded into CGRAM when LCD_CGRAM_EN is defined.
package lcd_pkg;

  localparam int CNT_W = 20;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] CMD_CGRAM    = 8'h40;

  localparam logic [3:0] S_PWR_WAIT = 4'd0;
  localparam logic [3:0] S_INIT     = 4'd1;
  localparam logic [3:0] S_CG_ADDR  = 4'd2;
  localparam logic [3:0] S_CG_DATA  = 4'd3;
  localparam logic [3:0] S_IDLE     = 4'd4;
  localparam logic [3:0] S_SET_L1   = 4'd5;
  localparam logic [3:0] S_FETCH_L1 = 4'd6;
  localparam logic [3:0] S_WR_L1    = 4'd7;
  localparam logic [3:0] S_SET_L2   = 4'd8;
  localparam logic [3:0] S_FETCH_L2 = 4'd9;
  localparam logic [3:0] S_WR_L2    = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_PULSE = 2'd2;
  localparam logic [1:0] PH_WAIT  = 2'd3;

  // 8 glyphs x 8 rows, 5-bit pixels: play, pause, vol1..3, repeat, shuffle, in-order
  localparam logic [7:0] GLYPH_ROM [64] = '{
    8'h10, 8'h18, 8'h1C, 8'h1E, 8'h1C, 8'h18, 8'h10, 8'h00,
    8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h1F,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h1F, 8'h1F, 8'h1F,
    8'h00, 8'h00, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h1F,
    8'h01, 8'h0F, 8'h11, 8'h10, 8'h11, 8'h1E, 8'h10, 8'h00,
    8'h00, 8'h13, 8'h0C, 8'h08, 8'h0C, 8'h13, 8'h00, 8'h00,
    8'h00, 8'h04, 8'h0E, 8'h1F, 8'h04, 8'h04, 8'h04, 8'h00
  };

  // Power-on command order; index 4 (clear) is the last and the only long one
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = CMD_FUNC_SET;
      3'd2:       init_cmd = CMD_DISP_ON;
      3'd3:       init_cmd = CMD_ENTRY;
      default:    init_cmd = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus write: latch RS/DATA, hold E low for the setup time, pulse
// E, then wait out the controller execution time. RS/DATA stay on the pins
// until the next byte is accepted. byte_done_o marks the last wait cycle.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = 2,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2_000,
  parameter int CLR_WAIT_CYC = 82_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       e_o,
  output logic       rs_o,
  output logic [7:0] data_o,
  output logic       byte_done_o
);

  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d, rs_q, rs_d, long_q, long_d;
  logic [7:0]       data_q, data_d;

  assign e_o         = e_q;
  assign rs_o        = rs_q;
  assign data_o      = data_q;
  assign byte_done_o = (phase_q == PH_WAIT) && (cnt_q == '0);

  // Phase sequencing with a shared down-counter for each timed interval
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    case (phase_q)
      PH_IDLE: begin
        if (start_i) begin
          phase_d = PH_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          rs_d    = rs_i;
          data_d  = data_i;
          long_d  = long_wait_i;
        end
      end
      PH_SETUP: begin
        if (cnt_q == '0) begin
          phase_d = PH_PULSE;
          e_d     = 1'b1;
          cnt_d   = CNT_W'(E_PULSE_CYC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      PH_PULSE: begin
        if (cnt_q == '0) begin
          phase_d = PH_WAIT;
          e_d     = 1'b0;
          cnt_d   = long_q ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
        if (cnt_q == '0) phase_d = PH_IDLE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
    endcase
  end

  // Registers; reset drops E immediately even mid-pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 16x2 sequencer: power-on init, optional CGRAM glyph load, then
// full two-line repaints from the 32-byte character buffer on request.
// Define LCD_CGRAM_EN to load the 8 custom glyphs after init.
//
// state      | meaning
// PWR_WAIT   | power-on delay; first init byte issued on the last cycle
// INIT       | 0x38 0x38 0x0C 0x06 0x01
// CG_ADDR    | 0x40 (LCD_CGRAM_EN only)
// CG_DATA    | 64 glyph rows, RS=1 (LCD_CGRAM_EN only)
// IDLE       | waiting for refresh_req
// SET_L1/L2  | DDRAM address for line 1 / line 2
// FETCH_Lx   | buf_addr presented, data returns next cycle
// WR_Lx      | character write, RS=1
// DONE       | one-cycle end-of-repaint pulse; repaint has finished
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int PWR_WAIT_CYC = 750_000,
  parameter int SETUP_CYC    = 2,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2_000,
  parameter int CLR_WAIT_CYC = 82_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh_req,
  output logic [4:0] buf_addr,
  input  logic [7:0] buf_data,
  output logic       init_done,
  output logic       busy,
  output logic       done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_ON,
  output logic [7:0] LCD_DATA
);

  if (CLK_HZ < 1) begin : g_clk_hz_check
    $error("CLK_HZ must be positive");
  end

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic             issued_q, issued_d, pending_q, pending_d;
  logic             init_done_q, init_done_d, lcd_on_q;
  logic             wr_start, wr_rs, wr_long, byte_done, in_wr, in_line2;
  logic [7:0]       wr_data;

  assign in_line2  = (state_q == S_SET_L2) || (state_q == S_FETCH_L2) || (state_q == S_WR_L2);
  assign in_wr     = (state_q == S_INIT) || (state_q == S_CG_ADDR) || (state_q == S_CG_DATA) ||
                     (state_q == S_SET_L1) || (state_q == S_SET_L2) ||
                     (state_q == S_WR_L1) || (state_q == S_WR_L2);
  // Issuing the first init byte from PWR_WAIT puts the first E rise at PWR_WAIT_CYC+SETUP_CYC
  assign wr_start  = (in_wr && !issued_q) || (state_q == S_PWR_WAIT && cnt_q == '0);
  assign wr_long   = !wr_rs && (wr_data == CMD_CLEAR);
  assign buf_addr  = {in_line2, idx_q[3:0]};
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign init_done = init_done_q;
  assign LCD_RW    = 1'b0;
  assign LCD_ON    = lcd_on_q;

  // Byte to put on the bus for the current state
  always_comb begin
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    case (state_q)
      S_PWR_WAIT, S_INIT: wr_data = init_cmd(idx_q[2:0]);
`ifdef LCD_CGRAM_EN
      S_CG_ADDR: wr_data = CMD_CGRAM;
      S_CG_DATA: begin
        wr_rs   = 1'b1;
        wr_data = GLYPH_ROM[idx_q];
      end
`endif
      S_SET_L1: wr_data = CMD_LINE1;
      S_SET_L2: wr_data = CMD_LINE2;
      S_WR_L1, S_WR_L2: begin
        wr_rs   = 1'b1;
        wr_data = buf_data;
      end
      default: ;
    endcase
  end

  // Sequencer next state; each byte state issues once and advances on byte_done
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    issued_d    = issued_q;
    pending_d   = pending_q;
    init_done_d = init_done_q;
    if (wr_start) issued_d = 1'b1;
    if (refresh_req && busy) pending_d = 1'b1;
    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == '0) state_d = S_INIT;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_INIT: begin
        if (byte_done) begin
          issued_d = 1'b0;
          if (idx_q == 6'd4) begin
            idx_d = '0;
`ifdef LCD_CGRAM_EN
            state_d = S_CG_ADDR;
`else
            state_d     = S_SET_L1;
            init_done_d = 1'b1;
`endif
          end else idx_d = idx_q + 6'd1;
        end
      end
`ifdef LCD_CGRAM_EN
      S_CG_ADDR: begin
        if (byte_done) begin
          issued_d = 1'b0;
          state_d  = S_CG_DATA;
        end
      end
      S_CG_DATA: begin
        if (byte_done) begin
          issued_d = 1'b0;
          idx_d    = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d     = S_SET_L1;
            init_done_d = 1'b1;
          end
        end
      end
`endif
      S_IDLE: begin
        if (refresh_req || pending_q) state_d = S_SET_L1;
      end
      S_SET_L1, S_SET_L2: begin
        if (byte_done) begin
          issued_d = 1'b0;
          state_d  = (state_q == S_SET_L1) ? S_FETCH_L1 : S_FETCH_L2;
        end
      end
      S_FETCH_L1: state_d = S_WR_L1;
      S_FETCH_L2: state_d = S_WR_L2;
      S_WR_L1, S_WR_L2: begin
        if (byte_done) begin
          issued_d = 1'b0;
          idx_d    = {2'b00, idx_q[3:0] + 4'd1};
          if (idx_q[3:0] != 4'hF) state_d = (state_q == S_WR_L1) ? S_FETCH_L1 : S_FETCH_L2;
          else state_d = (state_q == S_WR_L1) ? S_SET_L2 : S_DONE;
        end
      end
      default: begin
        // DONE: any requests seen during the repaint collapse into one more
        pending_d = 1'b0;
        state_d   = (pending_q || refresh_req) ? S_SET_L1 : S_IDLE;
      end
    endcase
  end

  // Sequencer registers; LCD_ON comes up on the first cycle out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWR_WAIT;
      cnt_q       <= CNT_W'(PWR_WAIT_CYC - 1);
      idx_q       <= '0;
      issued_q    <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      lcd_on_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      issued_q    <= issued_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      lcd_on_q    <= 1'b1;
    end
  end

  lcd_byte_writer #(
    .SETUP_CYC   (SETUP_CYC),
    .E_PULSE_CYC (E_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_writer (
    .clk        (clk),
    .rst        (rst),
    .start_i    (wr_start),
    .rs_i       (wr_rs),
    .data_i     (wr_data),
    .long_wait_i(wr_long),
    .e_o        (LCD_E),
    .rs_o       (LCD_RS),
    .data_o     (LCD_DATA),
    .byte_done_o(byte_done)
  );

endmodule
